// File: rtl/musa_pkg.sv
// Shared constants and types for the MUSA multi-cycle control unit:
// opcode and ALU-function codes, stage encoding, PC-source encoding and
// the instruction classes produced by the decoder.
package musa_pkg;

  // Opcode field values (zero-extended when the opcode is wider than 6 bits)
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_NOP  = 6'b000001;
  localparam logic [5:0] OP_JR   = 6'b000010;
  localparam logic [5:0] OP_CALL = 6'b000011;
  localparam logic [5:0] OP_JPC  = 6'b000100;
  localparam logic [5:0] OP_RET  = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b001001;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BRFL = 6'b010001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // ALU function codes driven for immediate-form instructions
  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;

  // Pipeline stage encoding, visible on the state output
  typedef enum logic [2:0] {
    ST_IFH = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4,
    ST_HLT = 3'd5
  } state_t;

  // PC source select
  typedef enum logic [1:0] {
    BR_SEQ   = 2'b00,
    BR_REL   = 2'b01,
    BR_ABS   = 2'b10,
    BR_STACK = 2'b11
  } branch_t;

  // Instruction class from the decoder
  typedef enum logic [3:0] {
    CL_ILLEGAL,
    CL_NOP,
    CL_HALT,
    CL_RTYPE,
    CL_ITYPE,
    CL_LOAD,
    CL_STORE,
    CL_JR,
    CL_JPC,
    CL_BRFL,
    CL_CALL,
    CL_RET
  } iclass_t;

  // Stage following EX
  typedef enum logic [1:0] {
    PATH_IFH,
    PATH_WB,
    PATH_MEM
  } path_t;

endpackage

// File: rtl/musa_decode.sv
// Combinational instruction decoder: latched opcode/funct -> instruction
// class, ALU function, immediate select and the stage that follows EX.
// CALL/RET are only recognised when MUSA_CALLRET_EN is defined; otherwise
// they decode as illegal.
module musa_decode
  import musa_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FW  = 6
) (
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  funct,
  output iclass_t        iclass,
  output logic [FW-1:0]  alu_op,
  output logic           immediat,
  output path_t          path
);

  // Classify the opcode; anything unlisted stays illegal
  always_comb begin
    iclass   = CL_ILLEGAL;
    alu_op   = '0;
    immediat = 1'b0;
    path     = PATH_IFH;
    case (opcode)
      OPW'(OP_R): begin
        iclass = CL_RTYPE;
        alu_op = funct;
        path   = PATH_WB;
      end
      OPW'(OP_ADDI): begin
        iclass   = CL_ITYPE;
        alu_op   = FW'(ALU_ADD);
        immediat = 1'b1;
        path     = PATH_WB;
      end
      OPW'(OP_SUBI): begin
        iclass   = CL_ITYPE;
        alu_op   = FW'(ALU_SUB);
        immediat = 1'b1;
        path     = PATH_WB;
      end
      OPW'(OP_ANDI): begin
        iclass   = CL_ITYPE;
        alu_op   = FW'(ALU_AND);
        immediat = 1'b1;
        path     = PATH_WB;
      end
      OPW'(OP_ORI): begin
        iclass   = CL_ITYPE;
        alu_op   = FW'(ALU_OR);
        immediat = 1'b1;
        path     = PATH_WB;
      end
      OPW'(OP_LW): begin
        iclass   = CL_LOAD;
        alu_op   = FW'(ALU_ADD);
        immediat = 1'b1;
        path     = PATH_MEM;
      end
      OPW'(OP_SW): begin
        iclass   = CL_STORE;
        alu_op   = FW'(ALU_ADD);
        immediat = 1'b1;
        path     = PATH_MEM;
      end
      OPW'(OP_JR):   iclass = CL_JR;
      OPW'(OP_JPC):  iclass = CL_JPC;
      OPW'(OP_BRFL): iclass = CL_BRFL;
      OPW'(OP_NOP):  iclass = CL_NOP;
      OPW'(OP_HALT): iclass = CL_HALT;
`ifdef MUSA_CALLRET_EN
      OPW'(OP_CALL): iclass = CL_CALL;
      OPW'(OP_RET):  iclass = CL_RET;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/musa_mc_control.sv
// MUSA multi-cycle control unit. Moore FSM IFH/ID/EX/MEM/WB/HLT driven by
// the latched instruction fields, with a bounded MEM-stage wait counter.
// Optional feature macro: MUSA_CALLRET_EN enables CALL (push) and RET (pop).
module musa_mc_control
  import musa_pkg::*;
#(
  parameter int OPW          = 6,
  parameter int FW           = 6,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  funct,
  input  logic           flag_true,
  input  logic           mem_ready,
  output logic           read_reg,
  output logic           write_reg,
  output logic           read_data,
  output logic           write_data,
  output logic           immediat,
  output logic           pc_write,
  output logic           push,
  output logic           pop,
  output logic [FW-1:0]  alu_op,
  output logic [1:0]     branch,
  output logic [2:0]     state,
  output logic           halted,
  output logic           illegal,
  output logic           mem_timeout
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX);

  state_t         state_reg, state_next;
  logic [OPW-1:0] opcode_reg;
  logic [FW-1:0]  funct_reg;
  logic [7:0]     wait_cnt_reg;
  logic           timeout_reg;
  logic           handshake;
  logic           mem_last;
  branch_t        branch_sel;

  iclass_t        dec_class;
  logic [FW-1:0]  dec_alu_op;
  logic           dec_immediat;
  path_t          dec_path;

  musa_decode #(
    .OPW (OPW),
    .FW  (FW)
  ) u_decode (
    .opcode   (opcode_reg),
    .funct    (funct_reg),
    .iclass   (dec_class),
    .alu_op   (dec_alu_op),
    .immediat (dec_immediat),
    .path     (dec_path)
  );

  // Fetch is offered only in IFH and never while reset is held
  assign instr_ready = (state_reg == ST_IFH) && !rst;
  assign handshake   = instr_valid && (state_reg == ST_IFH);
  assign mem_last    = (wait_cnt_reg == WAIT_LAST);
  assign state       = state_reg;
  assign branch      = branch_sel;
  assign mem_timeout = timeout_reg;

  // State, latched instruction fields, MEM wait counter and timeout pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IFH;
      opcode_reg   <= '0;
      funct_reg    <= '0;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (handshake) begin
        opcode_reg <= opcode;
        funct_reg  <= funct;
      end
      // Counter is zero on every MEM entry and counts MEM cycles spent
      if (state_reg == ST_MEM) begin
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end else begin
        wait_cnt_reg <= '0;
      end
      timeout_reg <= (state_reg == ST_MEM) && !mem_ready && mem_last;
    end
  end

  // Next-stage selection and per-stage strobes
  always_comb begin
    state_next = state_reg;
    read_reg   = 1'b0;
    write_reg  = 1'b0;
    read_data  = 1'b0;
    write_data = 1'b0;
    immediat   = 1'b0;
    pc_write   = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    alu_op     = '0;
    branch_sel = BR_SEQ;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (state_reg)
      ST_IFH: begin
        if (instr_valid) state_next = ST_ID;
      end
      ST_ID: begin
        read_reg = 1'b1;
        case (dec_class)
          CL_ILLEGAL: begin
            illegal    = 1'b1;
            state_next = ST_IFH;
          end
          CL_HALT: state_next = ST_HLT;
          CL_NOP:  state_next = ST_IFH;
          default: state_next = ST_EX;
        endcase
      end
      ST_EX: begin
        alu_op   = dec_alu_op;
        immediat = dec_immediat;
        case (dec_class)
          CL_JR: begin
            pc_write   = 1'b1;
            branch_sel = BR_ABS;
          end
          CL_JPC: begin
            pc_write   = 1'b1;
            branch_sel = BR_REL;
          end
          CL_BRFL: begin
            pc_write   = flag_true;
            branch_sel = BR_REL;
          end
`ifdef MUSA_CALLRET_EN
          CL_CALL: begin
            push       = 1'b1;
            pc_write   = 1'b1;
            branch_sel = BR_ABS;
          end
          CL_RET: begin
            pop        = 1'b1;
            pc_write   = 1'b1;
            branch_sel = BR_STACK;
          end
`endif
          default: ;
        endcase
        case (dec_path)
          PATH_WB:  state_next = ST_WB;
          PATH_MEM: state_next = ST_MEM;
          default:  state_next = ST_IFH;
        endcase
      end
      ST_MEM: begin
        // Strobe held every MEM cycle; the last permitted cycle may still complete
        if (dec_class == CL_LOAD) begin
          read_data = 1'b1;
        end else begin
          write_data = 1'b1;
        end
        if (mem_ready) begin
          state_next = (dec_class == CL_LOAD) ? ST_WB : ST_IFH;
        end else if (mem_last) begin
          state_next = ST_IFH;
        end
      end
      ST_WB: begin
        write_reg  = 1'b1;
        state_next = ST_IFH;
      end
      ST_HLT: begin
        halted = 1'b1;
      end
      default: state_next = ST_IFH;
    endcase
  end

endmodule

// File: tb/tb_musa_mc_control.sv
// Directed self-checking bench for musa_mc_control (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_musa_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       flag_true;
  logic       mem_ready;
  logic       read_reg, write_reg, read_data, write_data;
  logic       immediat, pc_write, push, pop;
  logic [5:0] alu_op;
  logic [1:0] branch;
  logic [2:0] state;
  logic       halted, illegal, mem_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  musa_mc_control #(
    .OPW          (6),
    .FW           (6),
    .MEM_WAIT_MAX (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .funct       (funct),
    .flag_true   (flag_true),
    .mem_ready   (mem_ready),
    .read_reg    (read_reg),
    .write_reg   (write_reg),
    .read_data   (read_data),
    .write_data  (write_data),
    .immediat    (immediat),
    .pc_write    (pc_write),
    .push        (push),
    .pop         (pop),
    .alu_op      (alu_op),
    .branch      (branch),
    .state       (state),
    .halted      (halted),
    .illegal     (illegal),
    .mem_timeout (mem_timeout)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for instr_ready, then present one instruction for one cycle.
  // Returns at the falling edge of the ID cycle.
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    int guard = 0;
    while (instr_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check_value("fetch_ready", {31'd0, instr_ready}, 32'd1);
    opcode      = op;
    funct       = fn;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    opcode      = '0;
    funct       = '0;
    flag_true   = 1'b0;
    mem_ready   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_value("rst_state", {29'd0, state}, 32'd0);
    check_value("rst_ready", {31'd0, instr_ready}, 32'd0);
    check_value("rst_strobes", {20'd0, read_reg, write_reg, read_data, write_data, immediat,
                pc_write, push, pop, halted, illegal, mem_timeout, branch == 2'b00}, 32'd1);
    check_value("rst_alu", {26'd0, alu_op}, 32'd0);
    rst = 1'b0;
    #1;
    check_value("ready_after_rst", {31'd0, instr_ready}, 32'd1);

    // ADD: IFH -> ID -> EX -> WB -> IFH
    fetch(6'b000000, 6'b100000);
    check_value("add_id_state", {29'd0, state}, 32'd1);
    check_value("add_id_readreg", {31'd0, read_reg}, 32'd1);
    @(negedge clk);
    check_value("add_ex_state", {29'd0, state}, 32'd2);
    check_value("add_ex_alu", {26'd0, alu_op}, 32'h20);
    check_value("add_ex_wreg", {31'd0, write_reg}, 32'd0);
    @(negedge clk);
    check_value("add_wb_state", {29'd0, state}, 32'd4);
    check_value("add_wb_wreg", {31'd0, write_reg}, 32'd1);
    @(negedge clk);
    check_value("add_ifh_state", {29'd0, state}, 32'd0);
    check_value("add_ifh_wreg", {31'd0, write_reg}, 32'd0);
    $display("txn ADD done");

    // SUBI: immediate select with ALU subtract
    fetch(6'b001001, 6'b000000);
    @(negedge clk);
    check_value("subi_ex_alu", {26'd0, alu_op}, 32'h22);
    check_value("subi_ex_imm", {31'd0, immediat}, 32'd1);
    @(negedge clk);
    check_value("subi_wb_state", {29'd0, state}, 32'd4);
    $display("txn SUBI done");

    // ORI
    fetch(6'b001101, 6'b000000);
    @(negedge clk);
    check_value("ori_ex_alu", {26'd0, alu_op}, 32'h25);
    $display("txn ORI done");

    // LW with mem_ready low for 3 MEM cycles
    fetch(6'b100011, 6'b000000);
    @(negedge clk);
    check_value("lw_ex_alu", {26'd0, alu_op}, 32'h20);
    check_value("lw_ex_imm", {31'd0, immediat}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_value("lw_mem_state", {29'd0, state}, 32'd3);
      check_value("lw_mem_rdata", {31'd0, read_data}, 32'd1);
      if (i == 3) mem_ready = 1'b1;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    check_value("lw_wb_state", {29'd0, state}, 32'd4);
    check_value("lw_wb_rdata", {31'd0, read_data}, 32'd0);
    @(negedge clk);
    check_value("lw_ifh_ready", {31'd0, instr_ready}, 32'd1);
    $display("txn LW done");

    // SW with mem_ready never: timeout after 16 MEM cycles
    fetch(6'b101011, 6'b000000);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_value("sw_to_mem_state", {29'd0, state}, 32'd3);
      check_value("sw_to_wdata", {31'd0, write_data}, 32'd1);
      check_value("sw_to_flag_low", {31'd0, mem_timeout}, 32'd0);
    end
    @(negedge clk);
    check_value("sw_to_flag", {31'd0, mem_timeout}, 32'd1);
    check_value("sw_to_state", {29'd0, state}, 32'd0);
    check_value("sw_to_wdata_drop", {31'd0, write_data}, 32'd0);
    @(negedge clk);
    check_value("sw_to_flag_pulse", {31'd0, mem_timeout}, 32'd0);
    $display("txn SW timeout done");

    // SW with mem_ready on the last permitted cycle: completes, no timeout
    fetch(6'b101011, 6'b000000);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) mem_ready = 1'b1;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    check_value("sw_edge_state", {29'd0, state}, 32'd0);
    check_value("sw_edge_noflag", {31'd0, mem_timeout}, 32'd0);
    $display("txn SW edge done");

    // BRFL with flag low then high
    flag_true = 1'b0;
    fetch(6'b010001, 6'b000000);
    @(negedge clk);
    check_value("brfl0_pcw", {31'd0, pc_write}, 32'd0);
    check_value("brfl0_branch", {30'd0, branch}, 32'd1);
    @(negedge clk);
    check_value("brfl0_ifh", {29'd0, state}, 32'd0);
    flag_true = 1'b1;
    fetch(6'b010001, 6'b000000);
    @(negedge clk);
    check_value("brfl1_pcw", {31'd0, pc_write}, 32'd1);
    check_value("brfl1_branch", {30'd0, branch}, 32'd1);
    flag_true = 1'b0;
    $display("txn BRFL done");

    // JR and JPC
    fetch(6'b000010, 6'b000000);
    @(negedge clk);
    check_value("jr_pcw", {31'd0, pc_write}, 32'd1);
    check_value("jr_branch", {30'd0, branch}, 32'd2);
    fetch(6'b000100, 6'b000000);
    @(negedge clk);
    check_value("jpc_branch", {30'd0, branch}, 32'd1);
    $display("txn JR/JPC done");

    // Unknown opcode
    fetch(6'b110000, 6'b000000);
    check_value("ill_flag", {31'd0, illegal}, 32'd1);
    @(negedge clk);
    check_value("ill_ifh", {29'd0, state}, 32'd0);
    check_value("ill_pulse", {31'd0, illegal}, 32'd0);
    $display("txn illegal done");

    // CALL: behaviour depends on the build option
    fetch(6'b000011, 6'b000000);
`ifdef MUSA_CALLRET_EN
    @(negedge clk);
    check_value("call_push", {31'd0, push}, 32'd1);
    check_value("call_branch", {30'd0, branch}, 32'd2);
`else
    check_value("call_illegal", {31'd0, illegal}, 32'd1);
    @(negedge clk);
    check_value("call_push", {31'd0, push}, 32'd0);
`endif
    $display("txn CALL done");

    // Reset in the middle of a LW MEM stage
    fetch(6'b100011, 6'b000000);
    @(negedge clk);
    @(negedge clk);
    check_value("lwr_rdata", {31'd0, read_data}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_value("lwr_rdata_drop", {31'd0, read_data}, 32'd0);
    check_value("lwr_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("txn LW reset done");

    // HALT, held with fetches offered, then reset mid-cycle
    fetch(6'b111111, 6'b000000);
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_value("hlt_halted", {31'd0, halted}, 32'd1);
      check_value("hlt_state", {29'd0, state}, 32'd5);
      check_value("hlt_ready", {31'd0, instr_ready}, 32'd0);
    end
    instr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_value("hlt_rst_halted", {31'd0, halted}, 32'd0);
    check_value("hlt_rst_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_value("hlt_rst_ready", {31'd0, instr_ready}, 32'd1);
    $display("txn HALT done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
